// File: rtl/yz_stream_if.sv
// ----------------------------------------------------------------------------
// yz_stream_if
// Bundles the symbol input and the decoded outputs of the {y,z} stream
// decoder so the decoder and its environment share one connection.
//   sym_valid       symbol {y,z} present this cycle
//   y, z            symbol MSB / LSB
//   state           tracked encoder state (A=00 B=01 C=11 HUNT=10)
//   x_out, x_valid  recovered bit and its 1-cycle strobe
//   err             1-cycle strobe, illegal symbol sequence
//   data_word       packed recovered bits, first bit in [0]
//   word_valid      1-cycle strobe, data_word is a complete word
// Modports: master = symbol source / output consumer, slave = decoder.
// ----------------------------------------------------------------------------
interface yz_stream_if #(
  parameter int W = 4
);
  logic         sym_valid;
  logic         y;
  logic         z;
  logic [1:0]   state;
  logic         x_out;
  logic         x_valid;
  logic         err;
  logic [W-1:0] data_word;
  logic         word_valid;

  modport master (
    output sym_valid, y, z,
    input  state, x_out, x_valid, err, data_word, word_valid
  );

  modport slave (
    input  sym_valid, y, z,
    output state, x_out, x_valid, err, data_word, word_valid
  );
endinterface

// File: rtl/yz_stream_decoder.sv
// ----------------------------------------------------------------------------
// yz_stream_decoder
// Receive-side inverse of the 3-state x->{y,z} Mealy encoder
//   A(00): x=1 -> 11, go C; x=0 -> 01, go B
//   B(01): 10, x ? C : B
//   C(11): 00, x ? C : A
// Every symbol's class (11/01 -> A, 10 -> B, 00 -> C) is the encoder state
// that emitted it, so the class of the next symbol reveals the encoder's
// next state and therefore the bit x that went with the previous symbol.
// Recovered bits are packed LSB-first into W-bit words.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   yz_stream_if.slave (symbol in, decoded outputs out)
// ----------------------------------------------------------------------------
module yz_stream_decoder #(
  parameter int W = 4
) (
  input logic       clk,
  input logic       rst,
  yz_stream_if.slave bus
);

  localparam logic [1:0] ST_A    = 2'b00;
  localparam logic [1:0] ST_B    = 2'b01;
  localparam logic [1:0] ST_C    = 2'b11;
  localparam logic [1:0] ST_HUNT = 2'b10;

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [1:0]    sym;
  logic [1:0]    sym_class;
  logic [1:0]    last_sym;   // last accepted symbol; its bit is still pending
  logic          legal;
  logic          x_bit;
  logic [CW-1:0] count;

  assign sym = {bus.y, bus.z};

  always_comb begin
    case (sym)
      2'b10:   sym_class = ST_B;
      2'b00:   sym_class = ST_C;
      default: sym_class = ST_A;
    endcase
  end

  // In every legal transition the pending bit is 1 exactly when the new
  // symbol is class C: the encoder only enters C on x=1 and only leaves
  // toward A/B on x=0.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    legal = 1'b0;
    x_bit = (sym_class == ST_C);
    case (last_sym)
      2'b11:   legal = (sym_class == ST_C);
      2'b01:   legal = (sym_class == ST_B);
      2'b10:   legal = (sym_class == ST_B) || (sym_class == ST_C);
      default: legal = (sym_class == ST_C) || (sym_class == ST_A);
    endcase
  end

  // NOTE: the reset is in the sensitivity list, so it takes effect at once
  // rather than waiting for the next clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.state      <= ST_HUNT;
      last_sym       <= 2'b00;
      count          <= '0;
      bus.x_out      <= 1'b0;
      bus.x_valid    <= 1'b0;
      bus.err        <= 1'b0;
      bus.data_word  <= '0;
      bus.word_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees the values from
      // before this edge, independent of statement order.
      bus.x_valid    <= 1'b0;
      bus.err        <= 1'b0;
      bus.word_valid <= 1'b0;
      if (bus.sym_valid) begin
        if (bus.state == ST_HUNT) begin
          // Only a class-A symbol can start alignment; B/C are dropped.
          if (sym_class == ST_A) begin
            bus.state <= ST_A;
            last_sym  <= sym;
          end
        end else if (legal) begin
          bus.x_valid          <= 1'b1;
          bus.x_out            <= x_bit;
          bus.data_word[count] <= x_bit;
          bus.state            <= sym_class;
          last_sym             <= sym;
          if (count == CW'(W - 1)) begin
            bus.word_valid <= 1'b1;
            count          <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          // Drop pending bit and partial word; the offending symbol is not
          // reconsidered as an alignment candidate.
          bus.err   <= 1'b1;
          count     <= '0;
          bus.state <= ST_HUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_yz_stream_decoder.sv
// ----------------------------------------------------------------------------
// tb_yz_stream_decoder
// Self-checking bench for yz_stream_decoder (W=4): a vector table with fixed
// expectations, hand-written multi-cycle sequences (gaps, word restart after
// an error, asynchronous reset) and a randomized stream, all additionally
// compared against an encoder-based reference model.
// ----------------------------------------------------------------------------
module tb_yz_stream_decoder;

  localparam int W = 4;
  localparam int MA = 0, MB = 1, MC = 2;   // model encoder states

  logic clk;
  logic rst;

  yz_stream_if #(.W(W)) bus ();

  yz_stream_decoder #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sym_cls(input logic [1:0] s);
    if (s == 2'b10) return MB;
    if (s == 2'b00) return MC;
    return MA;
  endfunction

  function automatic logic [1:0] enc_out(input int st, input bit x);
    if (st == MA) return x ? 2'b11 : 2'b01;
    if (st == MB) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int enc_next(input int st, input bit x);
    if (st == MA) return x ? MC : MB;
    if (st == MB) return x ? MC : MB;
    return x ? MC : MA;
  endfunction

  function automatic logic [1:0] st_code(input int c);
    if (c == MA) return 2'b00;
    if (c == MB) return 2'b01;
    return 2'b11;
  endfunction

  // Legal if some x makes the encoder, sitting in the class of p, emit p and
  // move into the class of s.
  function automatic bit m_legal(input logic [1:0] p, input logic [1:0] s, output bit xb);
    xb = 1'b0;
    for (int x = 0; x < 2; x++) begin
      if (enc_out(sym_cls(p), x[0]) == p && enc_next(sym_cls(p), x[0]) == sym_cls(s)) begin
        xb = x[0];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  bit           m_hunt;
  logic [1:0]   m_last;
  int           m_cnt;
  logic [W-1:0] m_word;
  logic         m_xv, m_x, m_err, m_wv;

  task automatic model_reset();
    m_hunt = 1'b1; m_last = 2'b00; m_cnt = 0; m_word = '0;
    m_xv = 1'b0; m_x = 1'b0; m_err = 1'b0; m_wv = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] s);
    bit xb;
    m_xv = 1'b0; m_err = 1'b0; m_wv = 1'b0;
    if (!v) return;
    if (m_hunt) begin
      if (sym_cls(s) == MA) begin
        m_hunt = 1'b0;
        m_last = s;
      end
    end else if (m_legal(m_last, s, xb)) begin
      m_xv = 1'b1; m_x = xb;
      m_word[m_cnt] = xb;
      m_cnt++;
      if (m_cnt == W) begin
        m_wv = 1'b1;
        m_cnt = 0;
      end
      m_last = s;
    end else begin
      m_err = 1'b1; m_hunt = 1'b1; m_cnt = 0;
    end
  endtask

  function automatic logic [1:0] m_state();
    return m_hunt ? 2'b10 : st_code(sym_cls(m_last));
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " state"}, 32'(bus.state), 32'(m_state()));
    check({tag, " x_valid"}, 32'(bus.x_valid), 32'(m_xv));
    check({tag, " err"}, 32'(bus.err), 32'(m_err));
    check({tag, " word_valid"}, 32'(bus.word_valid), 32'(m_wv));
    if (m_xv) check({tag, " x_out"}, 32'(bus.x_out), 32'(m_x));
    if (m_wv) check({tag, " data_word"}, 32'(bus.data_word), 32'(m_word));
  endtask

  // Drive one cycle (inputs change 1 time unit after an edge), then sample
  // 1 time unit after the next rising edge.
  task automatic apply(input logic v, input logic [1:0] s, input string tag);
    bus.sym_valid = v;
    bus.y = s[1];
    bus.z = s[0];
    @(posedge clk);
    model_step(v, s);
    #1;
    compare_model(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst state"}, 32'(bus.state), 32'(2'b10));
    check({tag, " rst x_out"}, 32'(bus.x_out), 32'd0);
    check({tag, " rst x_valid"}, 32'(bus.x_valid), 32'd0);
    check({tag, " rst err"}, 32'(bus.err), 32'd0);
    check({tag, " rst data_word"}, 32'(bus.data_word), 32'd0);
    check({tag, " rst word_valid"}, 32'(bus.word_valid), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.sym_valid = 1'b0;
    bus.y = 1'b0;
    bus.z = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_outputs(tag);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rs;     // reset before applying this vector
    logic [1:0] sym;
    logic [1:0] st;
    logic       xv;
    logic       x;
    logic       er;
    logic       wv;
    logic [3:0] word;
  } vec_t;

  vec_t vecs[14];

  logic [1:0] seq1[6];
  logic       bits_q[$];
  logic [3:0] words_q[$];

  initial begin
    int wv_cnt;
    int tx;
    logic [1:0] s;
    logic [10:0] pat;
    logic [4:0] pat2;
    bit dummy;

    // scenario 1: 11,00,01,10,10,00
    vecs[0]  = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0001};
    vecs[5]  = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
    // scenario 2: 11 then illegal 10, then 01,10
    vecs[6]  = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[7]  = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[8]  = '{1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    // scenario 3: B/C dropped in HUNT, then 11,00
    vecs[10] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[11] = '{1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[13] = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};

    rst = 1'b1;
    bus.sym_valid = 1'b0;
    bus.y = 1'b0;
    bus.z = 1'b0;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (vecs[i].rs) do_reset(t);
      apply(1'b1, vecs[i].sym, t);
      check({t, " tbl state"}, 32'(bus.state), 32'(vecs[i].st));
      check({t, " tbl x_valid"}, 32'(bus.x_valid), 32'(vecs[i].xv));
      check({t, " tbl err"}, 32'(bus.err), 32'(vecs[i].er));
      check({t, " tbl word_valid"}, 32'(bus.word_valid), 32'(vecs[i].wv));
      if (vecs[i].xv) check({t, " tbl x_out"}, 32'(bus.x_out), 32'(vecs[i].x));
      if (vecs[i].wv) check({t, " tbl data_word"}, 32'(bus.data_word), 32'(vecs[i].word));
    end

    // scenario 4: scenario 1 with 1-3 idle cycles between symbols
    seq1 = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    do_reset("gap");
    bits_q.delete();
    words_q.delete();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, seq1[i], "gap sym");
      if (bus.x_valid) bits_q.push_back(bus.x_out);
      if (bus.word_valid) words_q.push_back(bus.data_word);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        s = 2'($urandom);
        apply(1'b0, s, "gap idle");
      end
    end
    check("gap bit count", 32'(bits_q.size()), 32'd5);
    if (bits_q.size() == 5) begin
      check("gap bits", 32'({bits_q[4], bits_q[3], bits_q[2], bits_q[1], bits_q[0]}),
            32'(5'b10001));
    end
    check("gap word count", 32'(words_q.size()), 32'd1);
    if (words_q.size() == 1) check("gap word", 32'(words_q[0]), 32'(4'b0001));

    // scenario 5: 11 legal symbols (10 bits), illegal symbol, word restart
    do_reset("s5");
    pat = 11'b111_0100_1101;   // b0 = pat[0]
    tx = MA;
    wv_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      s = enc_out(tx, pat[i]);
      tx = enc_next(tx, pat[i]);
      apply(1'b1, s, $sformatf("s5 sym%0d", i));
      if (bus.word_valid) wv_cnt++;
      if (i == 8) check("s5 words after 9 symbols", 32'(wv_cnt), 32'd2);
      if (i == 4) check("s5 word0", 32'(bus.data_word), 32'(pat[3:0]));
    end
    for (int c = 0; c < 4; c++) begin
      if (!m_legal(s, 2'(c), dummy)) begin
        s = 2'(c);
        break;
      end
    end
    apply(1'b1, s, "s5 illegal");
    check("s5 err", 32'(bus.err), 32'd1);
    check("s5 err state", 32'(bus.state), 32'(2'b10));
    pat2 = 5'b11001;           // first bit (pat2[0]) rides on symbol 11
    tx = MA;
    for (int i = 0; i < 5; i++) begin
      s = enc_out(tx, pat2[i]);
      tx = enc_next(tx, pat2[i]);
      apply(1'b1, s, $sformatf("s5 restart%0d", i));
    end
    check("s5 restart word_valid", 32'(bus.word_valid), 32'd1);
    check("s5 restart word", 32'(bus.data_word), 32'(4'b1001));

    // scenario 6: asynchronous reset between clock edges, mid-word
    do_reset("s6");
    for (int i = 0; i < 6; i++) apply(1'b1, seq1[i], "s6 pre");
    check("s6 pre x_valid", 32'(bus.x_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("s6 async");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    apply(1'b1, 2'b01, "s6 post0");
    check("s6 post0 state", 32'(bus.state), 32'(2'b00));
    check("s6 post0 x_valid", 32'(bus.x_valid), 32'd0);
    apply(1'b1, 2'b10, "s6 post1");
    check("s6 post1 x_valid", 32'(bus.x_valid), 32'd1);
    check("s6 post1 x_out", 32'(bus.x_out), 32'd0);

    // randomized stream: mostly encoder output, some noise and idle cycles
    do_reset("rnd");
    tx = MA;
    for (int i = 0; i < 600; i++) begin
      int r;
      bit b;
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        s = 2'($urandom);
        apply(1'b0, s, "rnd idle");
      end else if (r < 3) begin
        s = 2'($urandom);
        apply(1'b1, s, "rnd noise");
      end else begin
        b = 1'($urandom);
        s = enc_out(tx, b);
        tx = enc_next(tx, b);
        apply(1'b1, s, "rnd enc");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
